place_random_tile: RTL and testbench

Parametrised successor of the fixed 4x4 "place a four" spawner. Takes an NxN board snapshot and chooses one empty cell uniformly at random with a free-running LFSR. It writes a 2 or a 4 into that cell; the value is random (probability set by a parameter) or forced by a mode input. Sits between the move/merge engine and the board register in the game2048 datapath. It also reports the placement coordinates and a board-full flag, which the game-over logic uses.

---
 rtl/game2048_pkg.sv | 34 +++
 rtl/tile_lfsr.sv | 20 ++
 rtl/place_random_tile.sv | 140 ++++++++++++++
 tb/tb_place_random_tile.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/game2048_pkg.sv
// Shared tile constants, encodings and LFSR parameters for the game2048 datapath.
package game2048_pkg;

  localparam int TILE_2 = 2;
  localparam int TILE_4 = 4;

  localparam int LFSR_W = 16;
  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    MODE_RAND  = 2'd0,
    MODE_TWO   = 2'd1,
    MODE_FOUR  = 2'd2,
    MODE_RAND3 = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_PICK,
    S_PLACE,
    S_DONE
  } state_e;

  function automatic logic want_four(input mode_e m, input logic [7:0] r, input int thresh);
    case (m)
      MODE_TWO:  return 1'b0;
      MODE_FOUR: return 1'b1;
      default:   return (int'({24'd0, r}) < thresh);
    endcase
  endfunction

endpackage

// File: rtl/tile_lfsr.sv
// Free-running Fibonacci LFSR; advances every cycle, reloads SEED on reset.
module tile_lfsr
  import game2048_pkg::*;
#(
  parameter int               WIDTH = LFSR_W,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (rst) q <= SEED;
    else     q <= {q[WIDTH-2:0], ^(q & TAPS)};
  end

endmodule

// File: rtl/place_random_tile.sv
// Picks one empty cell of an NxN board uniformly at random and writes a 2 or 4 into it.
// Fixed latency: done arrives 2*N*N+2 cycles after start is accepted.
module place_random_tile
  import game2048_pkg::*;
#(
  parameter int              N           = 4,
  parameter int              CELL_W      = 12,
  parameter int              FOUR_THRESH = 26,
  parameter logic [15:0]     SEED        = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [CELL_W-1:0]      board_in  [N][N],
  output logic [CELL_W-1:0]      board_out [N][N],
  output logic                   done,
  output logic                   busy,
  output logic                   full,
  output logic [$clog2(N)-1:0]   placed_row,
  output logic [$clog2(N)-1:0]   placed_col,
  output logic [CELL_W-1:0]      placed_val
);

  localparam int RW    = $clog2(N);
  localparam int CNT_W = $clog2(N*N+1);

  logic [LFSR_W-1:0] lfsr;

  tile_lfsr #(.WIDTH(LFSR_W), .SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  state_e             state;
  mode_e              mode_q;
  logic [CELL_W-1:0]  work [N][N];
  logic [RW-1:0]      row, col, hit_row, hit_col;
  logic [CNT_W-1:0]   empty_cnt, seen, target;
  logic [CELL_W-1:0]  value;
  logic               commit;

  logic cell_empty, last_cell;
  assign cell_empty = (work[row][col] == '0);
  assign last_cell  = (row == RW'(N-1)) && (col == RW'(N-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      mode_q     <= MODE_RAND;
      board_out  <= '{default: '0};
      done       <= 1'b0;
      busy       <= 1'b0;
      full       <= 1'b0;
      placed_row <= '0;
      placed_col <= '0;
      placed_val <= '0;
      row        <= '0;
      col        <= '0;
      hit_row    <= '0;
      hit_col    <= '0;
      empty_cnt  <= '0;
      seen       <= '0;
      target     <= '0;
      value      <= '0;
      commit     <= 1'b0;
    end else begin
      done <= 1'b0;

      // Row-major scan position shared by COUNT and PLACE; wraps to (0,0).
      if (state == S_COUNT || (state == S_PLACE && !commit)) begin
        if (col == RW'(N-1)) begin
          col <= '0;
          row <= last_cell ? '0 : row + RW'(1);
        end else begin
          col <= col + RW'(1);
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            work      <= board_in;
            mode_q    <= mode_e'(mode);
            empty_cnt <= '0;
            row       <= '0;
            col       <= '0;
            busy      <= 1'b1;
            state     <= S_COUNT;
          end
        end

        S_COUNT: begin
          if (cell_empty) empty_cnt <= empty_cnt + CNT_W'(1);
          if (last_cell)  state <= S_PICK;
        end

        S_PICK: begin
          target <= CNT_W'(({8'd0, empty_cnt} * {{CNT_W{1'b0}}, lfsr[7:0]}) >> 8);
          value  <= want_four(mode_q, lfsr[15:8], FOUR_THRESH) ? CELL_W'(TILE_4) : CELL_W'(TILE_2);
          seen   <= '0;
          commit <= 1'b0;
          state  <= S_PLACE;
        end

        S_PLACE: begin
          if (!commit) begin
            if (cell_empty) begin
              if (seen == target && empty_cnt != '0) begin
                work[row][col] <= value;
                hit_row        <= row;
                hit_col        <= col;
              end
              seen <= seen + CNT_W'(1);
            end
            if (last_cell) commit <= 1'b1;
          end else begin
            // Extra cycle after the scan publishes the finished working copy.
            board_out  <= work;
            full       <= (empty_cnt == '0);
            placed_row <= (empty_cnt == '0) ? '0 : hit_row;
            placed_col <= (empty_cnt == '0) ? '0 : hit_col;
            placed_val <= (empty_cnt == '0) ? '0 : value;
            done       <= 1'b1;
            state      <= S_DONE;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_place_random_tile.sv
// Directed bench for place_random_tile at N=4/CELL_W=12 and N=5/CELL_W=16.
module tb_place_random_tile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start4, start5;
  logic [1:0]  mode4, mode5;
  logic [11:0] bin4  [4][4];
  logic [11:0] bout4 [4][4];
  logic        done4, busy4, full4;
  logic [1:0]  prow4, pcol4;
  logic [11:0] pval4;
  logic [15:0] bin5  [5][5];
  logic [15:0] bout5 [5][5];
  logic        done5, busy5, full5;
  logic [2:0]  prow5, pcol5;
  logic [15:0] pval5;

  place_random_tile #(.N(4), .CELL_W(12)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode4),
    .board_in(bin4), .board_out(bout4), .done(done4), .busy(busy4), .full(full4),
    .placed_row(prow4), .placed_col(pcol4), .placed_val(pval4)
  );

  place_random_tile #(.N(5), .CELL_W(16)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .mode(mode5),
    .board_in(bin5), .board_out(bout5), .done(done5), .busy(busy5), .full(full5),
    .placed_row(prow5), .placed_col(pcol5), .placed_val(pval5)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run4(input logic [1:0] md, output int lat);
    @(posedge clk); #1;
    mode4 = md; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0;
    while (lat < 200 && !done4) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done4) lat = -1;
  endtask

  task automatic run5(input logic [1:0] md, output int lat);
    @(posedge clk); #1;
    mode5 = md; start5 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0;
    lat = 0;
    while (lat < 200 && !done5) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done5) lat = -1;
  endtask

  // nd: cells differing from bin4; nz: non-zero cells in bout4
  task automatic scan4(output int nd, output int nz);
    nd = 0; nz = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (bout4[r][c] !== bin4[r][c]) nd++;
        if (bout4[r][c] != 12'd0) nz++;
      end
  endtask

  task automatic fill4(input logic [11:0] v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) bin4[r][c] = v;
  endtask

  int lat, nd, nz, ndone, first, fours, run_err;
  logic [15:0] hits;

  initial begin
    rst = 1'b1; start4 = 1'b0; start5 = 1'b0; mode4 = 2'd0; mode5 = 2'd0;
    fill4(12'd0);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) bin5[r][c] = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    scan4(nd, nz);
    check("rst_done", done4, 0);
    check("rst_busy", busy4, 0);
    check("rst_full", full4, 0);
    check("rst_pval", pval4, 0);
    check("rst_board_zero", nz, 0);
    rst = 1'b0;

    // Column 3 empty, forced 4.
    fill4(12'd8);
    for (int r = 0; r < 4; r++) bin4[r][3] = 12'd0;
    run4(2'd2, lat);
    scan4(nd, nz);
    check("t1_latency", lat, 34);
    check("t1_busy_at_done", busy4, 1);
    check("t1_col", pcol4, 3);
    check("t1_val", pval4, 4);
    check("t1_full", full4, 0);
    check("t1_cell", bout4[prow4][3], 4);
    check("t1_diffs", nd, 1);

    // Single empty cell at (2,1), forced 2.
    fill4(12'd16);
    bin4[2][1] = 12'd0;
    run4(2'd1, lat);
    scan4(nd, nz);
    check("t2_row", prow4, 2);
    check("t2_col", pcol4, 1);
    check("t2_cell", bout4[2][1], 2);
    check("t2_val", pval4, 2);
    check("t2_full", full4, 0);
    check("t2_diffs", nd, 1);

    // Full board: distinct non-zero values pass through untouched.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) bin4[r][c] = 12'(r * 256 + c + 1);
    run4(2'd0, lat);
    scan4(nd, nz);
    check("t3_latency", lat, 34);
    check("t3_full", full4, 1);
    check("t3_val", pval4, 0);
    check("t3_row", prow4, 0);
    check("t3_col", pcol4, 0);
    check("t3_diffs", nd, 0);

    // Reset in the middle of COUNT.
    @(posedge clk); #1;
    mode4 = 2'd2; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    scan4(nd, nz);
    check("t5_busy", busy4, 0);
    check("t5_done", done4, 0);
    check("t5_full", full4, 0);
    check("t5_board_zero", nz, 0);
    fill4(12'd8);
    for (int r = 0; r < 4; r++) bin4[r][3] = 12'd0;
    run4(2'd2, lat);
    check("t5_rerun_latency", lat, 34);
    check("t5_rerun_col", pcol4, 3);

    // Second start mid-run must be ignored.
    @(posedge clk); #1;
    mode4 = 2'd1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    ndone = 0; first = -1;
    for (int c = 1; c <= 80; c++) begin
      if (c == 5) start4 = 1'b1;
      if (c == 6) start4 = 1'b0;
      @(posedge clk); #1;
      if (done4) begin
        ndone++;
        if (first < 0) first = c;
      end
    end
    check("t6_done_count", ndone, 1);
    check("t6_done_cycle", first, 34);
    check("t6_idle_after", busy4, 0);

    // Empty board, random mode, many runs.
    fill4(12'd0);
    fours = 0; run_err = 0; hits = '0;
    for (int k = 0; k < 2000; k++) begin
      run4(2'd0, lat);
      scan4(nd, nz);
      if (lat != 34 || full4 !== 1'b0 || nz != 1) run_err++;
      if (bout4[prow4][pcol4] !== pval4) run_err++;
      if (pval4 == 12'd4) fours++;
      else if (pval4 != 12'd2) run_err++;
      hits[{prow4, pcol4}] = 1'b1;
    end
    check("t4_run_errors", run_err, 0);
    check("t4_four_ratio_ok", (fours >= 120 && fours <= 280), 1);
    check("t4_all_positions", hits, 16'hFFFF);

    // N=5 variant: column 4 empty, forced 4.
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) bin5[r][c] = (c == 4) ? 16'd0 : 16'd8;
    run5(2'd2, lat);
    nd = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if (bout5[r][c] !== bin5[r][c]) nd++;
    check("n5_latency", lat, 52);
    check("n5_col", pcol5, 4);
    check("n5_val", pval5, 4);
    check("n5_full", full5, 0);
    check("n5_cell", bout5[prow5][4], 4);
    check("n5_diffs", nd, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
